dtg: RTL



---
 rtl/dtg_pkg.sv | 26 ++
 rtl/dtg_if.sv | 20 ++
 rtl/dtg_phase_counter.sv | 55 +++++
 rtl/dtg.sv | 84 ++++++++
 4 files changed

// File: rtl/dtg_pkg.sv
// Shared types and default 1024x768 @ 60 Hz timing for the display timing generator.
package dtg_pkg;

    localparam int DEF_H_PIXELS = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_PIXELS = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;
    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    localparam int H_T = DEF_H_PIXELS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_T = DEF_V_PIXELS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int H_SYNC_START = DEF_H_PIXELS + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_PIXELS + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_e;

    typedef logic [11:0] cnt_t;

endpackage

// File: rtl/dtg_if.sv
// Video timing bundle from the timing generator to the overlay and map-lookup stages.
interface dtg_if;
    import dtg_pkg::*;

    logic horiz_sync;
    logic vert_sync;
    logic video_on;
    cnt_t pixel_row;
    cnt_t pixel_column;
    logic frame_tick;

    modport master (
        output horiz_sync, vert_sync, video_on, pixel_row, pixel_column, frame_tick
    );

    modport slave (
        input horiz_sync, vert_sync, video_on, pixel_row, pixel_column, frame_tick
    );

endinterface

// File: rtl/dtg_phase_counter.sv
// Free-running wrap counter with a four-phase (active/fp/sync/bp) FSM; used for both axes.
module dtg_phase_counter
    import dtg_pkg::*;
#(
    parameter int ACTIVE = DEF_H_PIXELS,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output cnt_t   count,
    output phase_e phase,   // phase of the count that loads on the next edge
    output logic   wrap
);

    localparam cnt_t LAST_ACT  = cnt_t'(ACTIVE - 1);
    localparam cnt_t LAST_FP   = cnt_t'(ACTIVE + FP - 1);
    localparam cnt_t LAST_SYNC = cnt_t'(ACTIVE + FP + SYNC - 1);
    localparam cnt_t LAST      = cnt_t'(ACTIVE + FP + SYNC + BP - 1);

    cnt_t   count_q, count_d;
    phase_e phase_q, phase_d;

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
            unique case (phase_q)
                PH_ACTIVE: if (count_q == LAST_ACT)  phase_d = PH_FP;
                PH_FP:     if (count_q == LAST_FP)   phase_d = PH_SYNC;
                PH_SYNC:   if (count_q == LAST_SYNC) phase_d = PH_BP;
                PH_BP:     if (count_q == LAST)      phase_d = PH_ACTIVE;
                default:                             phase_d = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count = count_q;
    assign phase = phase_d;
    assign wrap  = en && (count_q == LAST);

endmodule

// File: rtl/dtg.sv
// Display timing generator: row/column counters plus registered sync, blank and frame strobes.
// Optional DTG_PIPE_ALIGN_EN delays syncs and video_on by one clock to match registered pixel data.
module dtg
    import dtg_pkg::*;
#(
    parameter int   H_PIXELS    = DEF_H_PIXELS,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_PIXELS    = DEF_V_PIXELS,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic clk,
    input  logic reset,
    dtg_if.master vga
);

    cnt_t   h_count, v_count;
    phase_e h_phase_d, v_phase_d;
    logic   h_wrap, v_wrap;

    dtg_phase_counter #(
        .ACTIVE(H_PIXELS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_horiz (
        .clk(clk), .reset(reset), .en(1'b1),
        .count(h_count), .phase(h_phase_d), .wrap(h_wrap)
    );

    dtg_phase_counter #(
        .ACTIVE(V_PIXELS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_vert (
        .clk(clk), .reset(reset), .en(h_wrap),
        .count(v_count), .phase(v_phase_d), .wrap(v_wrap)
    );

    logic hs_q, vs_q, vo_q, ft_q;

    // Decoding next-state phases keeps the strobes coincident with the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q <= ~SYNC_ACTIVE;
            vs_q <= ~SYNC_ACTIVE;
            vo_q <= 1'b0;
            ft_q <= 1'b0;
        end else begin
            hs_q <= (h_phase_d == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs_q <= (v_phase_d == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vo_q <= (h_phase_d == PH_ACTIVE) && (v_phase_d == PH_ACTIVE);
            ft_q <= v_wrap;
        end
    end

`ifdef DTG_PIPE_ALIGN_EN
    logic hs_p_q, vs_p_q, vo_p_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_p_q <= ~SYNC_ACTIVE;
            vs_p_q <= ~SYNC_ACTIVE;
            vo_p_q <= 1'b0;
        end else begin
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
            vo_p_q <= vo_q;
        end
    end

    assign vga.horiz_sync = hs_p_q;
    assign vga.vert_sync  = vs_p_q;
    assign vga.video_on   = vo_p_q;
`else
    assign vga.horiz_sync = hs_q;
    assign vga.vert_sync  = vs_q;
    assign vga.video_on   = vo_q;
`endif

    assign vga.pixel_row    = v_count;
    assign vga.pixel_column = h_count;
    assign vga.frame_tick   = ft_q;

endmodule
